// File: rtl/dino_pkg.sv
// dino_pkg: obstacle type encoding, FSM states and screen constants shared by the dino game blocks.
package dino_pkg;
  localparam int X_W = 10;
  localparam int SCREEN_W = 640;
  localparam int SPAWN_X = SCREEN_W;
  typedef enum logic [1:0] {SMALL, LARGE, PAIR, BIRD} obs_type_e;
  typedef enum logic [1:0] {IDLE, COUNT, SPAWN} state_e;
endpackage

// File: rtl/obstacle_slot.sv
// obstacle_slot: one obstacle register (valid/x/type) with load, leftward move and retire at the screen edge.
module obstacle_slot import dino_pkg::*; #(
  parameter int W = X_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         step,
  input  logic         load,
  input  logic [W-1:0] load_x,
  input  obs_type_e    load_type,
  input  logic [3:0]   speed,
  output logic         valid,
  output logic [W-1:0] x,
  output obs_type_e    otype,
  output logic         free
);
  // free means usable on this tick: empty now, or retiring on this tick
  assign free = !valid || (x < W'(speed));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      x <= '0;
      otype <= SMALL;
    end else if (clr) begin
      valid <= 1'b0;
      x <= '0;
      otype <= SMALL;
    end else if (load) begin
      valid <= 1'b1;
      x <= load_x;
      otype <= load_type;
    end else if (step && valid) begin
      if (x < W'(speed)) valid <= 1'b0;
      else x <= x - W'(speed);
    end
  end
endmodule

// File: rtl/obstacle_spawner.sv
// obstacle_spawner: gap-counting spawn FSM feeding two scrolling obstacle slots.
// Define SPAWNER_SPEEDUP_EN to raise the scroll speed every SPEEDUP_TICKS effective ticks.
module obstacle_spawner #(
  parameter int X_W = dino_pkg::X_W,
  parameter int SPAWN_X = dino_pkg::SPAWN_X,
  parameter int MIN_GAP = 24,
  parameter int GAP_STEP = 2,
  parameter int INIT_SPEED = 4,
  parameter int MAX_SPEED = 12,
  parameter int SPEEDUP_TICKS = 600
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             run,
  input  logic             clear,
  input  logic [4:0]       random1,
  output logic [1:0]       obs_valid,
  output logic [2*X_W-1:0] obs_x,
  output logic [3:0]       obs_type,
  output logic [3:0]       speed,
  output logic             spawn
);
  import dino_pkg::*;
  state_e state;
  logic [7:0] gap;
  logic eff, want;
  logic [1:0] free, load, v;
  logic [X_W-1:0] x0, x1;
  obs_type_e t0, t1;
  assign eff = tick && run;
  assign want = eff && !clear && state == SPAWN;
  // slots move first, so a slot retiring this tick already counts as free
  assign load[0] = want && free[0];
  assign load[1] = want && !free[0] && free[1];
  assign obs_valid = v;
  assign obs_x = {x1, x0};
  assign obs_type = {t1, t0};
  obstacle_slot #(.W(X_W)) u_slot0 (
    .clk(clk), .rst_n(rst_n), .clr(clear), .step(eff), .load(load[0]),
    .load_x(X_W'(SPAWN_X)), .load_type(obs_type_e'(random1[4:3])), .speed(speed),
    .valid(v[0]), .x(x0), .otype(t0), .free(free[0])
  );
  obstacle_slot #(.W(X_W)) u_slot1 (
    .clk(clk), .rst_n(rst_n), .clr(clear), .step(eff), .load(load[1]),
    .load_x(X_W'(SPAWN_X)), .load_type(obs_type_e'(random1[4:3])), .speed(speed),
    .valid(v[1]), .x(x1), .otype(t1), .free(free[1])
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gap <= 8'(MIN_GAP);
      spawn <= 1'b0;
    end else if (clear) begin
      state <= IDLE;
      gap <= 8'(MIN_GAP);
      spawn <= 1'b0;
    end else begin
      spawn <= |load;
      if (eff && state == IDLE) state <= COUNT;
      if (eff && state == COUNT) begin
        gap <= gap - 8'd1;
        if (gap == 8'd1) state <= SPAWN;
      end
      if (|load) begin
        gap <= 8'(MIN_GAP + 32'(random1[3:0]) * GAP_STEP);
        state <= COUNT;
      end
    end
  end
`ifdef SPAWNER_SPEEDUP_EN
  logic [9:0] tcnt;
  logic wrap;
  assign wrap = tcnt == 10'(SPEEDUP_TICKS - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt <= '0;
      speed <= 4'(INIT_SPEED);
    end else if (clear) begin
      tcnt <= '0;
      speed <= 4'(INIT_SPEED);
    end else if (eff) begin
      tcnt <= wrap ? '0 : tcnt + 10'd1;
      if (wrap && speed < 4'(MAX_SPEED)) speed <= speed + 4'd1;
    end
  end
`else
  assign speed = 4'(INIT_SPEED > MAX_SPEED ? MAX_SPEED : INIT_SPEED);
`endif
endmodule

// File: tb/tb_obstacle_spawner.sv
// tb_obstacle_spawner: directed stimulus with a spawn scoreboard checked by an independent monitor.
module tb_obstacle_spawner;
  logic clk = 1'b0;
  logic rst_n, tick, run, clear;
  logic [4:0] random1;
  logic [1:0] obs_valid, v2;
  logic [19:0] obs_x, x2, hx;
  logic [3:0] obs_type, t2, speed, s2, hs;
  logic spawn, sp2;
  typedef struct {int t; int s; int ty; int x;} exp_t;
  exp_t sb[$];
  exp_t cur;
  int n_chk = 0, n_fail = 0, eff = 0;
  bit mon_on = 1'b1;

  always #5 clk = ~clk;

  obstacle_spawner dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .run(run), .clear(clear), .random1(random1),
    .obs_valid(obs_valid), .obs_x(obs_x), .obs_type(obs_type), .speed(speed), .spawn(spawn)
  );

  obstacle_spawner #(.SPAWN_X(643), .MIN_GAP(100)) dut2 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .run(run), .clear(clear), .random1(random1),
    .obs_valid(v2), .obs_x(x2), .obs_type(t2), .speed(s2), .spawn(sp2)
  );

  function automatic void chk(string n, int a, int e);
    n_chk++;
    if (a != e) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endfunction

  task automatic do_tick();
    @(negedge clk);
    tick = 1'b1;
    if (run) eff++;
    @(negedge clk);
    tick = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_on && spawn) begin
      if (sb.size() == 0) chk("unexpected_spawn_tick", eff, -1);
      else begin
        cur = sb.pop_front();
        chk("spawn_tick", eff, cur.t);
        chk("spawn_valid", int'(obs_valid[cur.s]), 1);
        chk("spawn_x", int'(obs_x[cur.s*10 +: 10]), cur.x);
        chk("spawn_type", int'(obs_type[cur.s*2 +: 2]), cur.ty);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; tick = 1'b0; run = 1'b0; clear = 1'b0; random1 = 5'b11111;
    repeat (3) @(negedge clk);
    chk("rst_valid", int'(obs_valid), 0);
    chk("rst_x", int'(obs_x), 0);
    chk("rst_type", int'(obs_type), 0);
    chk("rst_speed", int'(speed), 4);
    chk("rst_spawn", int'(spawn), 0);
    rst_n = 1'b1;
    sb.push_back('{26, 0, 3, 640});
    sb.push_back('{81, 1, 0, 640});
    sb.push_back('{187, 0, 1, 640});
    sb.push_back('{242, 1, 0, 640});
    run = 1'b1;
    while (eff < 265) begin
      do_tick();
      if (eff == 26) random1 = 5'b00000;
      if (eff == 40) begin
        hx = obs_x; hs = speed;
        run = 1'b0;
        repeat (100) do_tick();
        chk("pause_x", int'(obs_x), int'(hx));
        chk("pause_speed", int'(speed), int'(hs));
        chk("pause_valid", int'(obs_valid), 1);
        run = 1'b1;
      end
      if (eff == 81) random1 = 5'b01010;
      if (eff == 102) begin
        chk("d2_spawn_valid", int'(v2), 1);
        chk("d2_spawn_x", int'(x2[9:0]), 643);
        chk("d2_spawn_type", int'(t2[1:0]), 1);
      end
      if (eff == 106) begin
        chk("full_valid", int'(obs_valid), 3);
        chk("full_x0", int'(obs_x[9:0]), 320);
        chk("full_x1", int'(obs_x[19:10]), 540);
      end
      if (eff == 186) chk("pre_retire_x0", int'(obs_x[9:0]), 0);
      if (eff == 187) random1 = 5'b00101;
      if (eff == 262) begin
        chk("d2_x3_valid", int'(v2[0]), 1);
        chk("d2_x3_x", int'(x2[9:0]), 3);
      end
      if (eff == 263) begin
        chk("d2_retire_valid", int'(v2[0]), 0);
        chk("d2_retire_x", int'(x2[9:0]), 3);
      end
    end
    chk("sb_empty", sb.size(), 0);
    mon_on = 1'b0;
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    chk("clr_valid", int'(obs_valid), 0);
    chk("clr_x", int'(obs_x), 0);
    chk("clr_type", int'(obs_type), 0);
    chk("clr_speed", int'(speed), 4);
    repeat (26) do_tick();
    chk("restart_valid", int'(obs_valid), 1);
    chk("restart_x", int'(obs_x[9:0]), 640);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", int'(obs_valid), 0);
    chk("async_rst_x", int'(obs_x), 0);
    @(negedge clk); rst_n = 1'b1;
`ifdef SPAWNER_SPEEDUP_EN
    repeat (599) do_tick();
    chk("speed_599", int'(speed), 4);
    do_tick();
    chk("speed_600", int'(speed), 5);
    repeat (4800) do_tick();
    chk("speed_5400", int'(speed), 12);
    repeat (600) do_tick();
    chk("speed_sat", int'(speed), 12);
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    chk("speed_clr", int'(speed), 4);
    chk("speed_clr_valid", int'(obs_valid), 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/obstacle_spawner.md
# obstacle_spawner

Consumes the 5-bit pseudo-random value from the jump-driven LFSR and turns it into the obstacle stream for the game. On each game tick it counts down a randomised gap, places a new obstacle at the right screen edge, scrolls up to two live obstacles leftward at the current speed, and retires any that leave the screen. Its outputs feed the renderer and the collision checker.

## Interface
- `X_W`, default 10: width of x coordinates.
- `SPAWN_X`, default 640: x of a newly spawned obstacle.
- `MIN_GAP`, default 24: minimum ticks between spawns.
- `GAP_STEP`, default 2: ticks added per unit of the random gap field.
- `INIT_SPEED`, default 4: pixels per tick after reset/clear.
- `MAX_SPEED`, default 12: speed ceiling.
- `SPEEDUP_TICKS`, default 600: ticks between speed increments.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `tick` in 1: one-cycle game-frame strobe.
- `run` in 1: game active; when low, all state freezes.
- `clear` in 1: synchronous restart; dominates `tick`.
- `random1` in 5: LFSR value, sampled only on spawn/gap-load ticks.
- `obs_valid` out 2: per-slot live flag.
- `obs_x` out 2*X_W: slot i occupies bits [i*X_W +: X_W].
- `obs_type` out 4: 2 bits per slot (0 small cactus, 1 large cactus, 2 cactus pair, 3 bird).
- `speed` out 4: current scroll speed.
- `spawn` out 1: one-cycle pulse, registered, the cycle after a spawn tick.

## Operation
- Reset values: `obs_valid`=0, `obs_x`=0, `obs_type`=0, `spawn`=0, `speed`=INIT_SPEED, gap counter=MIN_GAP, FSM=IDLE.
- FSM states:
  - IDLE: on the first `tick` with `run`=1, go to COUNT.
  - COUNT: gap counter decrements once per effective tick (`tick`&`run`). When it reaches 0 on a tick, go to SPAWN.
  - SPAWN: on the next effective tick, if a slot is free, load the lowest free slot, pulse `spawn`, reload the gap counter and return to COUNT. If both slots are valid, stay in SPAWN; the spawn is pending, not dropped.
- Spawn load:
  - x = SPAWN_X.
  - type = `random1[4:3]`.
  - gap = MIN_GAP + `random1[3:0]`*GAP_STEP.
- Movement on every effective tick, for each valid slot:
  - If x < speed: clear valid. This is retirement; x keeps its old value.
  - Otherwise: x -= speed.
- Slot ordering per tick: movement/retirement is evaluated first, then a spawn may use a slot freed on that same tick.
- A newly spawned obstacle does not move on its spawn tick.
- `clear` (with or without `run`): all slots invalid, x/type 0, speed=INIT_SPEED, gap=MIN_GAP, FSM=IDLE, `spawn`=0.
- `run`=0: no decrement, no movement, no speedup, `spawn` stays 0. Outputs hold.
- Arithmetic:
  - Gap counter is 8 bits; the defaults' maximum of 54 fits.
  - Speed is 4 bits, saturating at MAX_SPEED.

## Timing
- All outputs are registered and update one `clk` after the qualifying `tick` cycle.
- `spawn` is high for exactly one clk.
- `tick` is never held more than one cycle. If it is, each high cycle counts as a tick.
- Reset asserted mid-game returns every output to its reset value immediately (asynchronously). Operation restarts in IDLE after deassertion.

## Configuration
- `SPAWNER_SPEEDUP_EN` defined:
  - A 10-bit tick counter counts effective ticks.
  - On reaching SPEEDUP_TICKS it wraps to 0 and `speed` increments, saturating at MAX_SPEED.
  - `clear` resets the counter.
- Undefined: `speed` is constant INIT_SPEED and there is no speedup counter.

## Structure
- Shared package `dino_pkg`: obstacle type enum (SMALL, LARGE, PAIR, BIRD), X_W, screen constants SPAWN_X/SCREEN_W.
- One sub-module, `obstacle_slot`:
  - Holds valid/x/type for one slot and implements load, move and retire.
  - Instantiated twice.
- The FSM, gap counter, slot allocation and speed logic stay in the top level.

## Test plan
- Reset then `run`=1 with ticks, `random1`=5'b00000: first spawn after 1+24 ticks (tick 25, SPAWN consumes one more). Slot0 x=640, type 0, `spawn` pulses once.
- `random1`=5'b11111 at gap load: next gap = 24+15*2 = 54 ticks. Spawn type 3.
- Both slots valid when the gap expires: no `spawn` until a slot retires (x < speed). Spawn then occurs on the same tick the slot frees, into that slot.
- Slot at x=3, speed=4, tick: valid drops, x unchanged at 3.
- `run`=0 for 100 ticks mid-countdown: x, gap and speed unchanged. Resume continues the count exactly.
- With `SPAWNER_SPEEDUP_EN`:
  - After 600 effective ticks, speed goes 4→5. After 5400 ticks it saturates at 12.
  - `clear` returns speed to 4 and all slots to invalid.
